spi_flash_responder: RTL

Synthesizable SPI flash responder (mode 0 slave) that emulates the command subset of the board's onboard flash that the bootloader's SPI master uses: JEDEC ID, status, write enable/disable, read, page program and 4 KB sector erase. It runs in the 48 MHz USB clock domain, oversamples the SPI pins, and backs a small on-chip byte memory. It sits on the SPI master side of the bootloader, in place of the physical flash, for hardware-in-loop bring-up and system simulation.

---
 rtl/spi_flash_responder.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: oversampled pins, opcode/address/data frame FSM,
// busy engine for page program and sector erase, backed by an on-chip byte array.
module spi_flash_responder #(
    parameter int          ADDR_W      = 12,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          PROG_CYCLES = 480
) (
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic spi_sck,
    input  logic spi_cs,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic busy,
    output logic wel,
    output logic cmd_err
);

    localparam int MEM_BYTES  = 1 << ADDR_W;
    localparam int SECT_BYTES = (MEM_BYTES < 4096) ? MEM_BYTES : 4096;
    localparam int CNT_MAX    = (PROG_CYCLES > SECT_BYTES) ? PROG_CYCLES : SECT_BYTES;
    localparam int CNT_W      = $clog2(CNT_MAX);

    localparam logic [ADDR_W-1:0] SECT_MASK = ADDR_W'(SECT_BYTES - 1);
    localparam logic [CNT_W-1:0]  PROG_LAST = CNT_W'(PROG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SECT_LAST = CNT_W'(SECT_BYTES - 1);

    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;
    localparam logic [7:0] OP_WREN = 8'h06;
    localparam logic [7:0] OP_WRDI = 8'h04;
    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_PP   = 8'h02;
    localparam logic [7:0] OP_SE   = 8'h20;

    typedef enum logic [2:0] {F_IDLE, F_CMD, F_ADDR, F_DATA, F_IGNORE} frame_e;
    typedef enum logic [1:0] {B_READY, B_PROG, B_ERASE} busy_e;

    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q, cs_prev_q;

    frame_e            fstate_q, fstate_d;
    busy_e             bstate_q, bstate_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [6:0]        shift_q, shift_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] ers_base_q, ers_base_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              got_byte_q, got_byte_d;
    logic              load_q, load_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              err_q, err_d;
    logic              wel_q, wel_d;

    // Contents are stored inverted so that a power-up value of all zeros reads as erased (0xFF).
    logic [7:0]        mem_inv_q [MEM_BYTES];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [7:0]        mem_wdata;
    logic [7:0]        rd_data;

    logic sck_s, cs_s, mosi_s;
    logic sck_rise, sck_fall, cs_rise, byte_done;
    logic [7:0] rx_byte;

    assign sck_s     = sck_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sck_rise  = sck_s & ~sck_prev_q;
    assign sck_fall  = ~sck_s & sck_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign rx_byte   = {shift_q, mosi_s};
    assign byte_done = ~cs_s & sck_rise & (bit_cnt_q == 3'd7);
    assign rd_data   = ~mem_inv_q[addr_q];

    assign busy     = (bstate_q != B_READY);
    assign wel      = wel_q;
    assign cmd_err  = err_q;
    assign spi_miso = miso_q;

    // Two-flop synchronizers and edge-detect history for the asynchronous SPI pins.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync_q  <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every flop sample its pre-edge value, so the chain shifts by one stage per clock.
            sck_sync_q  <= {sck_sync_q[0], spi_sck};
            cs_sync_q   <= {cs_sync_q[0], spi_cs};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sck_prev_q  <= sck_s;
            cs_prev_q   <= cs_s;
        end
    end

    // Next-state logic: frame decode, transmit byte selection, commit on CS rise, busy engine.
    always_comb begin
        // NOTE: every signal gets a default first so no path through this block can infer a latch.
        fstate_d   = fstate_q;
        bstate_d   = bstate_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        opcode_d   = opcode_q;
        byte_idx_d = byte_idx_q;
        addr_d     = addr_q;
        ers_base_d = ers_base_q;
        cnt_d      = cnt_q;
        got_byte_d = got_byte_q;
        load_d     = byte_done;
        tx_d       = tx_q;
        miso_d     = miso_q;
        err_d      = 1'b0;
        wel_d      = wel_q;
        mem_we     = 1'b0;
        mem_waddr  = addr_q;
        mem_wdata  = 8'hFF;

        // Busy engine: program is a pure delay, erase writes one byte per clock.
        case (bstate_q)
            B_PROG: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == PROG_LAST) bstate_d = B_READY;
            end
            B_ERASE: begin
                mem_we    = 1'b1;
                mem_waddr = ers_base_q | ADDR_W'(cnt_q);
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == SECT_LAST) bstate_d = B_READY;
            end
            default: ;
        endcase

        // Fetch the next response byte one clock after a byte completes.
        if (load_q) begin
            tx_d = 8'h00;
            if (fstate_q == F_DATA) begin
                case (opcode_q)
                    OP_RDID: begin
                        case (byte_idx_q)
                            2'd0:    tx_d = JEDEC_ID[23:16];
                            2'd1:    tx_d = JEDEC_ID[15:8];
                            2'd2:    tx_d = JEDEC_ID[7:0];
                            default: tx_d = 8'h00;
                        endcase
                        if (byte_idx_q != 2'd3) byte_idx_d = byte_idx_q + 1'b1;
                    end
                    OP_RDSR: tx_d = {6'b0, wel_q, busy};
                    OP_READ: begin
                        tx_d   = rd_data;
                        addr_d = addr_q + 1'b1;
                    end
                    default: tx_d = 8'h00;
                endcase
            end
        end

        if (cs_s) begin
            // CS high wins over any coincident SCK edge; only completed frames commit.
            fstate_d  = F_IDLE;
            bit_cnt_d = 3'd0;
            miso_d    = 1'b0;
            if (cs_rise && fstate_q == F_DATA) begin
                case (opcode_q)
                    OP_WREN: if (bit_cnt_q == 3'd0 && !got_byte_q) wel_d = 1'b1;
                    OP_WRDI: if (bit_cnt_q == 3'd0 && !got_byte_q) wel_d = 1'b0;
                    OP_PP: begin
                        if (got_byte_q) begin
                            bstate_d = B_PROG;
                            cnt_d    = '0;
                            wel_d    = 1'b0;
                        end
                    end
                    OP_SE: begin
                        if (bit_cnt_q == 3'd0) begin
                            bstate_d   = B_ERASE;
                            cnt_d      = '0;
                            ers_base_d = addr_q & ~SECT_MASK;
                            wel_d      = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            if (fstate_q == F_IDLE) begin
                fstate_d   = F_CMD;
                byte_idx_d = 2'd0;
                got_byte_d = 1'b0;
                tx_d       = 8'h00;
            end
            if (sck_rise) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                shift_d   = rx_byte[6:0];
            end
            if (byte_done) begin
                case (fstate_q)
                    F_CMD: begin
                        opcode_d   = rx_byte;
                        byte_idx_d = 2'd0;
                        if (busy && rx_byte != OP_RDSR && rx_byte != OP_RDID) begin
                            fstate_d = F_IGNORE;
                            err_d    = 1'b1;
                        end else begin
                            case (rx_byte)
                                OP_RDID, OP_RDSR, OP_WREN, OP_WRDI: fstate_d = F_DATA;
                                OP_READ: fstate_d = F_ADDR;
                                OP_PP, OP_SE: begin
                                    fstate_d = wel_q ? F_ADDR : F_IGNORE;
                                    err_d    = ~wel_q;
                                end
                                default: begin
                                    fstate_d = F_IGNORE;
                                    err_d    = 1'b1;
                                end
                            endcase
                        end
                    end
                    F_ADDR: begin
                        addr_d     = ADDR_W'({addr_q, rx_byte});
                        byte_idx_d = byte_idx_q + 1'b1;
                        if (byte_idx_q == 2'd2) begin
                            fstate_d   = F_DATA;
                            byte_idx_d = 2'd0;
                        end
                    end
                    F_DATA: begin
                        got_byte_d = 1'b1;
                        if (opcode_q == OP_PP) begin
                            mem_we    = 1'b1;
                            mem_wdata = rd_data & rx_byte;
                            addr_d    = {addr_q[ADDR_W-1:8], addr_q[7:0] + 8'd1};
                        end
                    end
                    default: ;
                endcase
            end
            if (fstate_q == F_IGNORE) miso_d = 1'b0;
            else if (sck_fall) miso_d = tx_q[~bit_cnt_q];
        end
    end

    // State registers for the frame FSM, busy engine and response path.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            fstate_q   <= F_IDLE;
            bstate_q   <= B_READY;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 7'd0;
            opcode_q   <= 8'd0;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            ers_base_q <= '0;
            cnt_q      <= '0;
            got_byte_q <= 1'b0;
            load_q     <= 1'b0;
            tx_q       <= 8'd0;
            miso_q     <= 1'b0;
            err_q      <= 1'b0;
            wel_q      <= 1'b0;
        end else begin
            fstate_q   <= fstate_d;
            bstate_q   <= bstate_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            opcode_q   <= opcode_d;
            byte_idx_q <= byte_idx_d;
            addr_q     <= addr_d;
            ers_base_q <= ers_base_d;
            cnt_q      <= cnt_d;
            got_byte_q <= got_byte_d;
            load_q     <= load_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            err_q      <= err_d;
            wel_q      <= wel_d;
        end
    end

    // Single write port shared by page program and sector erase.
    always_ff @(posedge clk_48mhz) begin
        // NOTE: the array has no reset so it maps onto RAM and survives a reset mid-operation.
        if (mem_we) mem_inv_q[mem_waddr] <= ~mem_wdata;
    end

endmodule
